// File: rtl/kab_io_pkg.sv
// kab_io_pkg: shared UART receiver types and constants for the KabIO subsystem.
package kab_io_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_CLKS_PER_BIT = 434;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: mid-bit sampling UART receiver with a one-entry valid/ready holding register.
// Define UART_PARITY_EN to expect an even-parity bit and expose ParityErr.
module uart_receiver
    import kab_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Din,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       FrameErr,
`ifdef UART_PARITY_EN
    output logic       ParityErr,
`endif
    output logic       Overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    uart_rx_state_t state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic s, s_q;
    logic half_tick, full_tick;
`ifdef UART_PARITY_EN
    logic par_bad;
`endif
    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(Clock), .rst(Reset), .d(Din), .q(s));
    always_comb begin
        half_tick = cnt == CW'(CLKS_PER_BIT / 2 - 1);
        full_tick = cnt == CW'(CLKS_PER_BIT - 1);
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            s_q      <= 1'b1;
            RxData   <= '0;
            RxValid  <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad   <= 1'b0;
            ParityErr <= 1'b0;
`endif
        end else begin
            s_q      <= s;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
`ifdef UART_PARITY_EN
            ParityErr <= 1'b0;
`endif
            if (RxValid && RxReady) RxValid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (s_q && !s) state <= START;
                end
                START: begin
                    cnt <= half_tick ? '0 : cnt + CW'(1);
                    if (half_tick) state <= s ? IDLE : DATA;
                end
                DATA: begin
                    cnt <= full_tick ? '0 : cnt + CW'(1);
                    if (full_tick) begin
                        shreg   <= {s, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BW'(1);
`ifdef UART_PARITY_EN
                        if (bit_idx == BW'(UART_DATA_BITS - 1)) state <= PARITY;
`else
                        if (bit_idx == BW'(UART_DATA_BITS - 1)) state <= STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    cnt <= full_tick ? '0 : cnt + CW'(1);
                    if (full_tick) begin
                        par_bad <= s ^ (^shreg);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    cnt <= full_tick ? '0 : cnt + CW'(1);
                    if (full_tick && s) begin
                        state <= IDLE;
`ifdef UART_PARITY_EN
                        ParityErr <= par_bad;
`endif
                        // Loading while a transfer completes keeps RxValid high.
                        if (!RxValid || RxReady) begin
                            RxData  <= shreg;
                            RxValid <= 1'b1;
                        end else begin
                            Overrun <= 1'b1;
                        end
                    end else if (full_tick) begin
                        FrameErr <= 1'b1;
                        state    <= BREAK;
                    end
                end
                BREAK: if (s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames checked by a byte scoreboard plus error-pulse counters.
module tb_uart_receiver;
    localparam int CPB = 16;
    logic clk = 1'b0;
    logic Reset, Din, RxReady;
    logic [7:0] RxData;
    logic RxValid, FrameErr, Overrun, perr;
    logic par_flip = 1'b0;
    int total = 0, bad = 0;
    int n_rx = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic [8:0] exp_q[$];

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .Clock(clk), .Reset(Reset), .Din(Din), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .FrameErr(FrameErr),
`ifdef UART_PARITY_EN
        .ParityErr(perr),
`endif
        .Overrun(Overrun)
    );
`ifndef UART_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!Reset) begin
            if (FrameErr) n_ferr++;
            if (Overrun) n_ovr++;
            if (perr) n_perr++;
            if (RxValid && RxReady) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte got=%0h exp=none", RxData);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("rx_byte", {23'd0, perr, RxData}, {23'd0, e});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stp);
        Din = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            Din = b[i];
            cyc(CPB);
        end
`ifdef UART_PARITY_EN
        Din = (^b) ^ par_flip;
        cyc(CPB);
`endif
        Din = stp;
        cyc(CPB);
    endtask

    initial begin
        int rx0, fe0, ov0, pe0;
        Din = 1'b1;
        RxReady = 1'b1;
        Reset = 1'b1;
        cyc(3);
        check("reset_rxvalid", {31'd0, RxValid}, 0);
        check("reset_rxdata", {24'd0, RxData}, 0);
        check("reset_frameerr", {31'd0, FrameErr}, 0);
        check("reset_overrun", {31'd0, Overrun}, 0);
        Reset = 1'b0;
        cyc(5);

        rx0 = n_rx; fe0 = n_ferr; ov0 = n_ovr;
        exp_q.push_back(9'h0A5);
        send(8'hA5, 1'b1);
        cyc(2 * CPB);
        check("a5_count", n_rx - rx0, 1);
        check("a5_no_ferr", n_ferr - fe0, 0);
        check("a5_no_ovr", n_ovr - ov0, 0);

        rx0 = n_rx; fe0 = n_ferr;
        Din = 1'b0;
        cyc(CPB / 4);
        Din = 1'b1;
        cyc(3 * CPB);
        check("glitch_no_rx", n_rx - rx0, 0);
        check("glitch_no_ferr", n_ferr - fe0, 0);

        rx0 = n_rx; fe0 = n_ferr;
        send(8'h3C, 1'b0);
        cyc(3 * CPB);
        check("break_ferr", n_ferr - fe0, 1);
        check("break_no_rx", n_rx - rx0, 0);
        Din = 1'b1;
        cyc(2 * CPB);
        exp_q.push_back(9'h011);
        send(8'h11, 1'b1);
        cyc(2 * CPB);
        check("after_break_rx", n_rx - rx0, 1);
        check("after_break_ferr", n_ferr - fe0, 1);

        rx0 = n_rx; ov0 = n_ovr;
        RxReady = 1'b0;
        exp_q.push_back(9'h001);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        cyc(2 * CPB);
        check("ovr_pulse", n_ovr - ov0, 1);
        check("ovr_held_data", {24'd0, RxData}, 32'h01);
        check("ovr_held_valid", {31'd0, RxValid}, 1);
        RxReady = 1'b1;
        cyc(2);
        check("ovr_drained", n_rx - rx0, 1);
        check("ovr_valid_drop", {31'd0, RxValid}, 0);

        rx0 = n_rx; fe0 = n_ferr; ov0 = n_ovr;
        Din = 1'b0; cyc(CPB);
        Din = 1'b1; cyc(CPB);
        Din = 1'b0; cyc(CPB);
        Din = 1'b1; cyc(CPB / 2);
        Reset = 1'b1;
        Din = 1'b1;
        cyc(1);
        check("midrst_rxdata", {24'd0, RxData}, 0);
        check("midrst_rxvalid", {31'd0, RxValid}, 0);
        check("midrst_ferr", {31'd0, FrameErr}, 0);
        check("midrst_ovr", {31'd0, Overrun}, 0);
        Reset = 1'b0;
        cyc(3 * CPB);
        exp_q.push_back(9'h07E);
        send(8'h7E, 1'b1);
        cyc(2 * CPB);
        check("midrst_rx", n_rx - rx0, 1);
        check("midrst_no_ferr", n_ferr - fe0, 0);
        check("midrst_no_ovr", n_ovr - ov0, 0);

`ifdef UART_PARITY_EN
        pe0 = n_perr;
        par_flip = 1'b1;
        exp_q.push_back(9'h107);
        send(8'h07, 1'b1);
        cyc(2 * CPB);
        check("parity_bad_pulse", n_perr - pe0, 1);
        par_flip = 1'b0;
        exp_q.push_back(9'h007);
        send(8'h07, 1'b1);
        cyc(2 * CPB);
        check("parity_good_nopulse", n_perr - pe0, 1);
`else
        pe0 = n_perr;
        check("no_parity_pulse", pe0, 0);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receiver for the KabIO subsystem: it recovers bytes from the asynchronous UART line that the chip's serial transmitter drives on `Dout`. It synchronizes the line, detects start bits and samples each bit at mid-period. Each byte is delivered on a valid/ready port into a one-entry holding register, and framing and overrun errors are flagged. It is used both as the bench-side decoder for `Dout` and as the on-chip receive path.

## Interface
- `CLKS_PER_BIT`, 434, Clock cycles per bit (50 MHz / 115200); must be ≥ 4.
- `Clock`  in  1  System clock; all logic on the rising edge.
- `Reset`  in  1  Synchronous, active-high reset.
- `Din`  in  1  Serial line, idle high; asynchronous to `Clock`.
- `RxData`  out  8  Received byte, LSB = first data bit.
- `RxValid`  out  1  `RxData` holds an unread byte.
- `RxReady`  in  1  Consumer accepts `RxData` when `RxValid && RxReady`.
- `FrameErr`  out  1  One-cycle pulse: stop bit sampled low.
- `Overrun`  out  1  One-cycle pulse: a completed byte was dropped because the holding register was full.
- `ParityErr`  out  1  One-cycle pulse: parity mismatch. Present only with `UART_PARITY_EN`.

## Operation
- `Din` passes through a 2-flop synchronizer; the synchronizer reset value is 1.
- Frame format: 1 start bit (0), 8 data bits LSB first, [parity bit], 1 stop bit (1).
- States and transitions:
  - **IDLE**: synchronized line falls 1→0 → START; bit counter cleared.
  - **START**: wait `CLKS_PER_BIT/2` (integer division) cycles, then sample.
    - Sample 1 → IDLE (glitch rejected, no error).
    - Sample 0 → DATA.
  - **DATA**: sample every `CLKS_PER_BIT` cycles and shift into the shift register MSB-side (right shift). After the 8th sample → PARITY if the macro is defined, else STOP.
  - **PARITY**: sample one bit and compare with the even parity of the data.
  - **STOP**: sample one bit.
    - Sample 1: byte complete → IDLE.
    - Sample 0: pulse `FrameErr`, discard the byte → BREAK.
  - **BREAK**: wait until the line is 1 → IDLE. This prevents a held-low line from being read as repeated start bits.
- Byte delivery on completion:
  - If `RxValid` is 0, or `RxReady` is 1 in the same cycle: load `RxData` and set `RxValid`.
  - Otherwise: hold the old byte and pulse `Overrun`.
- `RxValid` clears on the cycle after a transfer unless a new byte loads in that same cycle.
- `RxData` is stable while `RxValid && !RxReady`.
- A byte with a parity error is still delivered. `ParityErr` pulses in the same cycle the byte loads, or the same cycle `Overrun` pulses.

## Timing
- Reset values: `RxData` = 0, `RxValid` = 0, `FrameErr` = 0, `Overrun` = 0, `ParityErr` = 0, state = IDLE, synchronizer = 1.
- Reset asserted mid-frame aborts the frame immediately; no error pulse is produced.
- Bit sample points fall at `CLKS_PER_BIT/2 + k·CLKS_PER_BIT` cycles after the synchronized falling edge, for k = 0 … 9 (k = 0 … 10 with parity).
- Latency: `RxValid` rises 1 cycle after the stop-bit sample. From the line edge that is 2 synchronizer cycles + 1 detect cycle + the sample offset + 1.
- A new start edge is accepted in IDLE on the cycle after leaving STOP. This supports back-to-back frames with no idle bit.
- The bit counter width is `$clog2(CLKS_PER_BIT)`. The counter reloads at 0 with no wrap beyond `CLKS_PER_BIT-1`.

## Configuration
- `UART_PARITY_EN` defined:
  - Frame carries an even-parity bit between data and stop.
  - The PARITY state and the `ParityErr` port exist.
- `UART_PARITY_EN` undefined:
  - 10-bit frame.
  - No PARITY state and no `ParityErr` port.

## Structure
- Package `kab_io_pkg` holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `UART_DATA_BITS` = 8;
  - the default `CLKS_PER_BIT`.
- Sub-module `sync_2ff` is the reusable input synchronizer, with a reset value parameter.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16, `RxReady` = 1 unless stated.
1. Send 0xA5 with a valid frame → `RxValid` pulses once with `RxData` = 0xA5; no error pulses.
2. 0.25-bit low glitch on an idle line → no `RxValid`, no `FrameErr`; state returns to IDLE.
3. Send 0x3C with the stop bit forced low, then hold the line low for 3 bit times → one `FrameErr` pulse, no `RxValid`. After the line returns high, 0x11 is received correctly.
4. Hold `RxReady` = 0 and send 0x01 then 0x02 back-to-back → `RxData` = 0x01 is held and `Overrun` pulses once. Raising `RxReady` transfers 0x01, then `RxValid` drops.
5. Assert `Reset` for 1 cycle mid-DATA of 0x55, then send 0x7E → only 0x7E is delivered; all outputs are 0 after reset.
6. With `UART_PARITY_EN`, send 0x07 with a wrong parity bit → `RxData` = 0x07 with `ParityErr` pulsing in the same cycle. With correct parity, there is no pulse.
